data_memory: RTL and testbench

//  Word-addressed 32-bit data RAM for the single-cycle RISC-V datapath, fed by the ALU result (Address)
//  and rs2 (WD). Provides a combinational read, a synchronous write, and a synchronous clear of the

---
 rtl/data_memory_pkg.sv | 10 +
 rtl/data_memory_if.sv | 20 ++
 rtl/data_memory.sv | 32 +++
 tb/tb_data_memory.sv | 111 +++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared widths and the byte-address to word-index mapping for the data RAM
// Contents: XLEN, DMEM_DEPTH_LOG2_DEF, word_index()
package data_memory_pkg;
   localparam int XLEN = 32;
   localparam int DMEM_DEPTH_LOG2_DEF = 6;
   // Drops the byte offset and every bit above the array size, so addresses alias by array size
   function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] addr, input int unsigned depth_log2);
      return (addr >> 2) & ((XLEN'(1) << depth_log2) - XLEN'(1));
   endfunction
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: load/store bus between the datapath (master) and the data RAM (slave)
// Signals: address (byte address), wd (store data), mem_write (store enable), rd (load data),
//          misaligned (only with DMEM_ALIGN_CHECK_EN)
interface data_memory_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = data_memory_pkg::XLEN
);
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wd;
   logic              mem_write;
   logic [DATA_W-1:0] rd;
`ifdef DMEM_ALIGN_CHECK_EN
   logic              misaligned;
   modport master (output address, wd, mem_write, input rd, misaligned);
   modport slave (input address, wd, mem_write, output rd, misaligned);
`else
   modport master (output address, wd, mem_write, input rd);
   modport slave (input address, wd, mem_write, output rd);
`endif
endinterface

// File: rtl/data_memory.sv
// data_memory: word-addressed RAM with combinational read, synchronous write and synchronous clear
// Ports: clk_i   - clock, all updates on rising edge
//        rst_i   - synchronous active-high reset, clears every word, beats a store
//        bus     - data_memory_if slave: address/wd/mem_write in, rd out (misaligned out if enabled)
// Build option: DMEM_ALIGN_CHECK_EN adds bus.misaligned and suppresses misaligned stores
module data_memory
   import data_memory_pkg::*;
#(
   parameter int DATA_W     = XLEN,
   parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   data_memory_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] idx;
   logic                  we;
   assign idx    = DEPTH_LOG2'(word_index(XLEN'(bus.address), DEPTH_LOG2));
   assign bus.rd = mem_q[idx];
`ifdef DMEM_ALIGN_CHECK_EN
   assign bus.misaligned = bus.mem_write & (bus.address[1:0] != 2'b00);
   assign we = bus.mem_write & ~bus.misaligned;
`else
   assign we = bus.mem_write;
`endif
   always_ff @(posedge clk_i) begin
      if (rst_i) for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      else if (we) mem_q[idx] <= bus.wd;
   end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and random stores/loads checked against an array model of the RAM
module tb_data_memory;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] model [64];
   bit mvalid = 1'b0;
   data_memory_if bus ();
   data_memory dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   // Model: 64 words, word = (byte address / 4) mod 64
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) model[i] <= 32'd0;
         mvalid <= 1'b1;
      end else if (bus.mem_write && !(ALIGN && (bus.address % 4 != 0)))
         model[(bus.address / 4) % 64] <= bus.wd;
   end
   always @(negedge clk) begin
      if (mvalid) begin
         checks++;
         if (bus.rd !== model[(bus.address / 4) % 64]) begin
            errors++;
            $display("FAIL cycle_rd addr=%h got %h want %h", bus.address, bus.rd, model[(bus.address / 4) % 64]);
         end
`ifdef DMEM_ALIGN_CHECK_EN
         checks++;
         if (bus.misaligned !== (bus.mem_write && (bus.address % 4 != 0))) begin
            errors++;
            $display("FAIL cycle_misaligned got %b want %b", bus.misaligned, bus.mem_write && (bus.address % 4 != 0));
         end
`endif
      end
   end
   task automatic drive(input logic r, input logic w, input logic [31:0] d, input logic [31:0] a);
      @(negedge clk);
      #1;
      rst = r;
      bus.mem_write = w;
      bus.wd = d;
      bus.address = a;
   endtask
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, exp);
      end
   endtask
   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.mem_write = 1'b0;
      bus.wd = '0;
      bus.address = '0;
      edge_wait();
      drive(0, 0, 0, 32'hFFE8);
      #1 chk("reset_ffe8", bus.rd, 32'd0);
      bus.address = 32'h0000;
      #1 chk("reset_0000", bus.rd, 32'd0);
      bus.address = 32'h00FC;
      #1 chk("reset_00fc", bus.rd, 32'd0);
      drive(0, 1, 32'd14, 32'hFFE8);
      edge_wait();
      chk("write_ffe8", bus.rd, 32'd14);
      drive(0, 1, 32'd7, 32'hFFE4);
      edge_wait();
      chk("write_ffe4", bus.rd, 32'd7);
      drive(0, 0, 0, 32'hFFE8);
      #1 chk("comb_ffe8", bus.rd, 32'd14);
      bus.address = 32'hFFE4;
      #1 chk("comb_ffe4", bus.rd, 32'd7);
      drive(0, 1, 32'hDEADBEEF, 32'h0100);
      #1 chk("old_before_edge", bus.rd, 32'd0);
      edge_wait();
      drive(0, 0, 0, 32'h0000);
      #1 chk("alias_0000", bus.rd, 32'hDEADBEEF);
      drive(1, 1, 32'd5, 32'hFFE8);
      edge_wait();
      drive(0, 0, 0, 32'hFFE8);
      #1 chk("rst_prio_ffe8", bus.rd, 32'd0);
      bus.address = 32'hFFE4;
      #1 chk("rst_prio_ffe4", bus.rd, 32'd0);
      drive(0, 1, 32'h11, 32'h0004);
      edge_wait();
      drive(0, 1, 32'd9, 32'h0006);
`ifdef DMEM_ALIGN_CHECK_EN
      #1 chk("misaligned_flag", 32'(bus.misaligned), 32'd1);
`endif
      edge_wait();
      drive(0, 0, 0, 32'h0004);
      #1 chk("misaligned_store", bus.rd, ALIGN ? 32'h11 : 32'd9);
      for (int n = 0; n < 600; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
         drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), $urandom, a);
      end
      drive(0, 0, 0, 0);
      edge_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
